// File: rtl/nibble_scroll_shifter.sv
// Group shifter with fill modes and an autonomous scroll sequencer for the digit display path.
// Manual step/load land on the next edge; an automatic step lands every `period` clocks after start.
// No backpressure: load always wins, start/en are ignored while a scroll runs.
module nibble_scroll_shifter #(
  parameter int width  = 20,
  parameter int shbits = 4,
  parameter int cntw   = 8,
  parameter int period = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [width-1:0]  num,
  input  logic              load,
  input  logic              en,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic [shbits-1:0] fill,
  input  logic              start,
  input  logic [cntw-1:0]   steps,
  output logic [width-1:0]  out,
  output logic              busy,
  output logic              done
);

  // Refuse to build with a width that does not split into whole groups or a zero period.
  if (width == 0 || shbits == 0 || (width % shbits) != 0) begin : g_bad_width
    $error("nibble_scroll_shifter: width must be a non-zero multiple of shbits");
  end
  if (period < 1) begin : g_bad_period
    $error("nibble_scroll_shifter: period must be at least 1");
  end

  localparam int TW = (period > 1) ? $clog2(period) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(period - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state, nxt_state;
  logic [width-1:0]  nxt_out;
  logic              nxt_done;
  logic [TW-1:0]     tick, nxt_tick;
  logic [cntw-1:0]   remain, nxt_remain;
  logic              l_dir, nxt_l_dir;
  logic [1:0]        l_mode, nxt_l_mode;
  logic [shbits-1:0] l_fill, nxt_l_fill;

  // One group step; built with shifts so width==shbits needs no special slicing.
  function automatic logic [width-1:0] step_fn(input logic [width-1:0]  v,
                                               input logic              d,
                                               input logic [1:0]        m,
                                               input logic [shbits-1:0] f);
    logic [shbits-1:0] g;
    logic [width-1:0]  gx;
    case (m)
      2'b00:   g = d ? v[shbits-1:0] : v[width-1 -: shbits];
      2'b01:   g = '0;
      2'b10:   g = f;
      default: g = d ? {shbits{v[width-1]}} : '0;
    endcase
    gx = width'(g);
    if (d) step_fn = (v >> shbits) | (gx << (width - shbits));
    else   step_fn = (v << shbits) | gx;
  endfunction

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      out    <= '0;
      done   <= 1'b0;
      tick   <= '0;
      remain <= '0;
      l_dir  <= 1'b0;
      l_mode <= 2'b00;
      l_fill <= '0;
    end else begin
      state  <= nxt_state;
      out    <= nxt_out;
      done   <= nxt_done;
      tick   <= nxt_tick;
      remain <= nxt_remain;
      l_dir  <= nxt_l_dir;
      l_mode <= nxt_l_mode;
      l_fill <= nxt_l_fill;
    end
  end

  // Next-state: load first, then start/en in IDLE; timed steps with latched controls in RUN.
  always_comb begin
    nxt_state  = state;
    nxt_out    = out;
    nxt_done   = 1'b0;
    nxt_tick   = tick;
    nxt_remain = remain;
    nxt_l_dir  = l_dir;
    nxt_l_mode = l_mode;
    nxt_l_fill = l_fill;
    case (state)
      IDLE: begin
        if (load) begin
          nxt_out = num;
        end else if (start && steps == '0) begin
          nxt_done = 1'b1;
        end else if (start) begin
          nxt_l_dir  = dir;
          nxt_l_mode = mode;
          nxt_l_fill = fill;
          nxt_remain = steps;
          nxt_tick   = '0;
          nxt_state  = RUN;
        end else if (en) begin
          nxt_out = step_fn(out, dir, mode, fill);
        end
      end
      default: begin
        if (load) begin
          nxt_out    = num;
          nxt_tick   = '0;
          nxt_remain = '0;
          nxt_state  = IDLE;
        end else if (tick == TICK_LAST) begin
          nxt_out    = step_fn(out, l_dir, l_mode, l_fill);
          nxt_tick   = '0;
          nxt_remain = remain - 1'b1;
          if (remain == cntw'(1)) begin
            nxt_done  = 1'b1;
            nxt_state = IDLE;
          end
        end else begin
          nxt_tick = tick + 1'b1;
        end
      end
    endcase
  end

  // Busy simply reflects the RUN state so it drops with reset immediately.
  always_comb begin
    busy = (state == RUN);
  end

endmodule

// File: doc/nibble_scroll_shifter.md
Name: nibble_scroll_shifter

Overview:
- Parametrised successor to the team's bidirectional group-rotate register for the digit display path.
- Shifts a width-bit word by shbits-bit groups, one group per step.
- Adds fill modes (rotate, zero, constant, arithmetic) and an autonomous scroll sequencer: N steps, one step every `period` clocks, with busy/done handshake.
- Sits between the BCD value source and the seven-segment multiplexer; drives scrolling text/number effects without CPU involvement.

Parameters:
- width, 20, register width in bits; must be a non-zero multiple of shbits (elaboration error otherwise).
- shbits, 4, group size shifted per step.
- cntw, 8, width of the step-count input.
- period, 4, clocks between automatic steps; minimum 1.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous active-high reset.
- num  input  width  parallel load value.
- load  input  1  load num into out; highest priority.
- en  input  1  single manual step, honoured only when idle.
- dir  input  1  0 = shift toward MSB (left); 1 = shift toward LSB (right).
- mode  input  2  00 rotate; 01 zero fill; 10 constant fill; 11 arithmetic.
- fill  input  shbits  fill group for mode 10.
- start  input  1  begin an automatic scroll of `steps` steps.
- steps  input  cntw  number of automatic steps.
- out  output  width  register contents.
- busy  output  1  high while a scroll is running.
- done  output  1  one-cycle pulse when a scroll completes.

Behaviour:
- Reset (async, any state): out=0, busy=0, done=0, state IDLE, tick and remaining counters = 0.
- One step, left (dir=0): out <= {out[width-shbits-1:0], F}. Right (dir=1): out <= {F, out[width-1:shbits]}.
- F by mode:
  - 00 rotate: the group shifted out.
  - 01: zero.
  - 10: `fill`.
  - 11: left fills zero; right fills the replicated sign bit out[width-1], i.e. {shbits{out[width-1]}}.
- States: IDLE and RUN. done defaults to 0 every cycle.
- IDLE, per edge, in priority order:
  - load: out<=num.
  - else start with steps=0: done<=1, no shift, remain IDLE.
  - else start with steps>0: latch dir, mode, fill and steps; tick<=0; busy<=1; go to RUN.
  - else en: one step using live dir/mode/fill.
- RUN:
  - tick increments each clock. When tick==period-1: perform one step with the latched controls, tick<=0, remaining<=remaining-1.
  - k-th step lands at edge E0+k*period, where E0 is the start edge.
- Completion: on the edge applying the final step, busy<=0, done<=1 for exactly one cycle, and the state returns to IDLE. The final value and done are visible in the same cycle.
- load during RUN aborts the scroll: out<=num, busy<=0, state IDLE, tick and remaining cleared, no done pulse.
- Ignored while in RUN: start, en, and live dir/mode/fill changes.
- Reset mid-scroll: immediate return to reset values; no done pulse.
- period=1: one step per clock.
- width==shbits is legal: a step replaces the whole word with F, or leaves it unchanged under rotate.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> out=0x00000, busy=0, done=0 immediately, without waiting for a clock edge.
- Manual rotate: load 0x12345, then en with dir=0 mode=00 -> 0x23451; en with dir=1 -> 0x12345.
- Auto scroll: from 0x12345, start steps=3 dir=1 mode=01 at edge E0 (period=4):
  - out=0x01234 at E0+4, 0x00123 at E0+8, 0x00012 at E0+12.
  - done high only in the cycle after E0+12; busy high from E0 to E0+12.
  - start/en pulses during the scroll have no effect.
- Fill modes:
  - 0x9ABCD, mode 11 dir=1 -> 0xF9ABC.
  - 0x9ABCD, mode 11 dir=0 -> 0xABCD0.
  - 0x12345, mode 10 fill=0xE dir=0 -> 0x2345E.
- Abort: start steps=5 from 0x12345, then load num=0xABCDE at E0+6 -> out=0xABCDE, busy=0, done never pulses, next en steps normally.
- Edge cases:
  - start steps=0 -> done pulses next cycle, out unchanged, busy stays 0.
  - load and start on the same edge -> load wins, no scroll.
  - period=1, steps=5, mode 00 on 0x12345 -> returns to 0x12345 after 5 clocks, with done pulsing then.
